// File: rtl/veda_pkg.sv
// Shared types and default sizing for the veda memory controller.
package veda_pkg;
  localparam int VEDA_DW     = 32;
  localparam int VEDA_AW     = 5;
  localparam int VEDA_RD_LAT = 2;
  localparam int VEDA_CNT_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    WR,
    RD_WAIT,
    RSP,
    VERIFY
  } state_t;
endpackage

// File: rtl/veda_lat_cnt.sv
// Load-and-count-down timer; done is high whenever the count has reached zero.
module veda_lat_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/veda_ctrl.sv
// Single-word read/write controller for the veda register file; all outputs registered.
// Optional write-verify read-back is enabled by defining VEDA_CTRL_WRVERIFY_EN.
module veda_ctrl
  import veda_pkg::*;
#(
  parameter int DW     = VEDA_DW,
  parameter int AW     = VEDA_AW,
  parameter int RD_LAT = VEDA_RD_LAT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic          clr_req,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          mem_rst,
  output logic          mem_we,
  output logic          mem_mode,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam logic [VEDA_CNT_W-1:0] RD_LOAD = VEDA_CNT_W'(RD_LAT);

  state_t state, state_nxt;
  logic   accept;
  logic   cnt_load, cnt_done;
  logic   [VEDA_CNT_W-1:0] cnt_val;
  logic   req_ready_d, rsp_valid_d, mem_rst_d, mem_we_d, mem_mode_d;

  // req_ready is registered and cannot drop in the cycle clr_req shows up,
  // so the clear wins by gating acceptance here.
  assign accept = (state == IDLE) && req_ready && req_valid && !clr_req;

`ifdef VEDA_CTRL_WRVERIFY_EN
  localparam logic [VEDA_CNT_W-1:0] VF_LOAD = VEDA_CNT_W'(RD_LAT - 1);
  assign cnt_load = (accept && !req_write) || (state == WR);
  assign cnt_val  = (state == WR) ? VF_LOAD : RD_LOAD;
`else
  assign cnt_load = accept && !req_write;
  assign cnt_val  = RD_LOAD;
`endif

  veda_lat_cnt #(.W(VEDA_CNT_W)) u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (clr_req)     state_nxt = CLR;
        else if (accept) state_nxt = req_write ? WR : RD_WAIT;
      end
      CLR:     state_nxt = IDLE;
`ifdef VEDA_CTRL_WRVERIFY_EN
      WR:      state_nxt = VERIFY;
      VERIFY:  if (cnt_done) state_nxt = IDLE;
`else
      WR:      state_nxt = IDLE;
`endif
      RD_WAIT: if (cnt_done) state_nxt = RSP;
      RSP:     if (rsp_valid && rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control outputs are decoded from the next state, then registered below.
  always_comb begin
    req_ready_d = (state_nxt == IDLE);
    rsp_valid_d = (state_nxt == RSP);
    mem_rst_d   = (state_nxt == CLR);
    mem_we_d    = (state_nxt == WR);
    mem_mode_d  = (state_nxt == WR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      mem_rst   <= 1'b0;
      mem_we    <= 1'b0;
      mem_mode  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_rdata <= '0;
    end else begin
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      mem_rst   <= mem_rst_d;
      mem_we    <= mem_we_d;
      mem_mode  <= mem_mode_d;
      if (accept) begin
        mem_addr <= req_addr;
        if (req_write) mem_wdata <= req_wdata;
      end
      if (state == RD_WAIT && cnt_done) rsp_rdata <= mem_rdata;
    end
  end

`ifdef VEDA_CTRL_WRVERIFY_EN
  // mem_wdata still holds the word just written, so it is the verify reference.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_err <= 1'b0;
    end else if (state_nxt == CLR) begin
      rsp_err <= 1'b0;
    end else if (state == VERIFY && cnt_done && mem_rdata != mem_wdata) begin
      rsp_err <= 1'b1;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif
endmodule
